// File: rtl/spi_slave_reg_access.sv
// spi_slave_reg_access: SPI command front end that turns serial register commands into write strobes and serial read data
module spi_slave_reg_access #(
   parameter int         REG_SIZE  = 8,
   parameter logic [5:0] WR_OPCODE = 6'b000001,
   parameter logic [5:0] RD_OPCODE = 6'b000010
) (
   input  logic                sclk,
   input  logic                rstn,
   input  logic                cs_n,
   input  logic                sdi,
   output logic                sdo,
   output logic                sdo_oe,
   output logic [1:0]          wr_addr,
   output logic [REG_SIZE-1:0] wr_data,
   output logic                wr_data_valid,
   output logic [1:0]          rd_addr,
   input  logic [REG_SIZE-1:0] rd_data,
   output logic                cmd_err
);
   // one shift register serves both the 8-bit command and the data word
   localparam int SW = (REG_SIZE > 8) ? REG_SIZE : 8;
   localparam int CW = $clog2(SW);

   typedef enum logic [2:0] {CMD, WDATA, RTURN, RDATA, IGNORE} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [SW-2:0]       sr_q, sr_d;
   logic [REG_SIZE-1:0] tx_sr_q, tx_sr_d;
   logic [1:0]          waddr_q, waddr_d;
   logic [1:0]          wr_addr_q, wr_addr_d;
   logic [REG_SIZE-1:0] wr_data_q, wr_data_d;
   logic                wr_valid_q, wr_valid_d;
   logic [1:0]          rd_addr_q, rd_addr_d;
   logic                sdo_oe_q, sdo_oe_d;
   logic                cmd_err_q, cmd_err_d;
   logic [SW-1:0]       word;

   // word as it stands once the bit on sdi is taken in this cycle
   assign word = {sr_q, sdi};

   // state register and all datapath registers; rstn clears everything at once
   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= CMD;
         cnt_q      <= '0;
         sr_q       <= '0;
         tx_sr_q    <= '0;
         waddr_q    <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_valid_q <= 1'b0;
         rd_addr_q  <= '0;
         sdo_oe_q   <= 1'b0;
         cmd_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sr_q       <= sr_d;
         tx_sr_q    <= tx_sr_d;
         waddr_q    <= waddr_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         wr_valid_q <= wr_valid_d;
         rd_addr_q  <= rd_addr_d;
         sdo_oe_q   <= sdo_oe_d;
         cmd_err_q  <= cmd_err_d;
      end
   end

   // next-state and datapath decode; strobes default low so they last one cycle
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sr_d       = sr_q;
      tx_sr_d    = tx_sr_q;
      waddr_d    = waddr_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      wr_valid_d = 1'b0;
      rd_addr_d  = rd_addr_q;
      sdo_oe_d   = sdo_oe_q;
      cmd_err_d  = 1'b0;
      if (cs_n) begin
         state_d  = CMD;
         cnt_d    = '0;
         sdo_oe_d = 1'b0;
      end else begin
         case (state_q)
            CMD: begin
               sr_d  = word[SW-2:0];
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(7)) begin
                  cnt_d = '0;
                  if (word[7:2] == WR_OPCODE) begin
                     waddr_d = word[1:0];
                     state_d = WDATA;
                  end else if (word[7:2] == RD_OPCODE) begin
                     rd_addr_d = word[1:0];
                     state_d   = RTURN;
                  end else begin
                     cmd_err_d = 1'b1;
                     state_d   = IGNORE;
                  end
               end
            end
            WDATA: begin
               sr_d  = word[SW-2:0];
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(REG_SIZE - 1)) begin
                  cnt_d      = '0;
                  wr_data_d  = word[REG_SIZE-1:0];
                  wr_addr_d  = waddr_q;
                  wr_valid_d = 1'b1;
                  waddr_d    = waddr_q + 2'd1;
               end
            end
            RTURN: begin
               tx_sr_d   = rd_data;
               rd_addr_d = rd_addr_q + 2'd1;
               sdo_oe_d  = 1'b1;
               cnt_d     = '0;
               state_d   = RDATA;
            end
            RDATA: begin
               tx_sr_d = {tx_sr_q[REG_SIZE-2:0], 1'b0};
               cnt_d   = cnt_q + CW'(1);
               if (cnt_q == CW'(REG_SIZE - 1)) begin
                  tx_sr_d   = rd_data;
                  rd_addr_d = rd_addr_q + 2'd1;
                  cnt_d     = '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign sdo           = sdo_oe_q & tx_sr_q[REG_SIZE-1];
   assign sdo_oe        = sdo_oe_q;
   assign wr_addr       = wr_addr_q;
   assign wr_data       = wr_data_q;
   assign wr_data_valid = wr_valid_q;
   assign rd_addr       = rd_addr_q;
   assign cmd_err       = cmd_err_q;
endmodule
